// File: rtl/reg_file_scoreboard_if.sv
// Decode/issue, read-port and write-back signal bundle for reg_file_scoreboard.
// master = pipeline side driving requests, slave = the register file.
interface reg_file_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     flush;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ready;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_dest;
    logic                     issue_ready;
    logic                     wb_valid;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     busy_any;
    logic                     wb_err;

    modport master (
        output flush, rd_addr, issue_valid, issue_dest, wb_valid, wb_addr, wb_data,
        input  rd_data, rd_ready, issue_ready, busy_any, wb_err
    );

    modport slave (
        input  flush, rd_addr, issue_valid, issue_dest, wb_valid, wb_addr, wb_data,
        output rd_data, rd_ready, issue_ready, busy_any, wb_err
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending-write counters for RAW hazard stalls.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back data to read ports.
module reg_file_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input logic                  clk,
    input logic                  reset,
    reg_file_scoreboard_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regData [NUM_REGS];
    logic [CNT_W-1:0]  cntVal  [NUM_REGS];
    logic [NUM_REGS-1:0] regBusy;
    logic issueHitWb;
    logic issueFire;
    logic wbErrReg;

    // A write-back in the same cycle frees the slot the new issue would take.
    assign issueHitWb      = bus.wb_valid && (bus.wb_addr == bus.issue_dest);
    assign bus.issue_ready = (cntVal[bus.issue_dest] != CNT_MAX) || issueHitWb;
    assign issueFire       = bus.issue_valid && bus.issue_ready && !bus.flush;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : gReg
            if (gi == 0) begin : gZero
                assign regData[gi] = '0;
                assign cntVal[gi]  = '0;
                assign regBusy[gi] = 1'b0;
            end else begin : gLive
                logic [DATA_W-1:0] dataReg;
                logic [CNT_W-1:0]  cntReg;
                logic              incHit;
                logic              wbHit;

                assign incHit = issueFire && (bus.issue_dest == ADDR_W'(gi));
                assign wbHit  = bus.wb_valid && (bus.wb_addr == ADDR_W'(gi));

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        dataReg <= '0;
                        cntReg  <= '0;
                    end else begin
                        if (wbHit)
                            dataReg <= bus.wb_data;
                        // Flush squashes every reservation; issue+wb together nets to zero.
                        if (bus.flush)
                            cntReg <= '0;
                        else if (incHit && !wbHit)
                            cntReg <= cntReg + CNT_W'(1);
                        else if (wbHit && !incHit && (cntReg != '0))
                            cntReg <= cntReg - CNT_W'(1);
                    end
                end

                assign regData[gi] = dataReg;
                assign cntVal[gi]  = cntReg;
                assign regBusy[gi] = (cntReg != '0);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wbErrReg <= 1'b0;
        else if (bus.wb_valid && (bus.wb_addr != '0) && !bus.flush &&
                 (cntVal[bus.wb_addr] == '0))
            wbErrReg <= 1'b1;
    end

    assign bus.wb_err   = wbErrReg;
    assign bus.busy_any = |regBusy;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : gRead
            logic [ADDR_W-1:0] rdIdx;
            assign rdIdx = bus.rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
            logic bypass;
            assign bypass = bus.wb_valid && (bus.wb_addr == rdIdx) && (rdIdx != '0);
            assign bus.rd_data[gi*DATA_W +: DATA_W] = bypass ? bus.wb_data : regData[rdIdx];
            // The in-flight write retires this cycle, so one pending write is fine.
            assign bus.rd_ready[gi] = bypass ? (cntVal[rdIdx] <= CNT_W'(1))
                                             : (cntVal[rdIdx] == '0);
`else
            assign bus.rd_data[gi*DATA_W +: DATA_W] = regData[rdIdx];
            assign bus.rd_ready[gi] = (cntVal[rdIdx] == '0);
`endif
        end
    endgenerate
endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Parametrised successor to the core register file. Provides NUM_RD combinational read ports and one synchronous write-back port. Adds a per-register pending-write counter (scoreboard) so decode can stall on RAW hazards and issue multiple in-flight writes to one destination. Sits between decode/issue and write-back stages of the pipelined processor.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
NUM_RD, 2, number of read ports
CNT_W, 2, pending-write counter width; max in-flight writes per register = 2**CNT_W-1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
flush  input  1  synchronous clear of all pending counters (pipeline squash)
rd_addr  input  NUM_RD*ADDR_W  packed read indices, port k at [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data
rd_ready  output  NUM_RD  1 = register k has no outstanding write (value usable)
issue_valid  input  1  decode requests reservation of issue_dest
issue_dest  input  ADDR_W  destination register being issued
issue_ready  output  1  reservation accepted this cycle
wb_valid  input  1  write-back strobe
wb_addr  input  ADDR_W  write-back index
wb_data  input  DATA_W  write-back value
busy_any  output  1  OR of all pending counters non-zero
wb_err  output  1  sticky: write-back seen to a register with zero pending count

Behaviour:
- Reset (async, immediate): all registers 0, all counters 0, wb_err 0. Hence rd_data 0, rd_ready all 1, busy_any 0, issue_ready 1.
- Register 0: always reads 0, rd_ready always 1, never written, counter held at 0. Issue to r0 accepted (issue_ready 1) with no effect; write-back to r0 ignored, never sets wb_err.
- Reads: combinational, zero latency. rd_ready[k] = (cnt[rd_addr k] == 0).
- Write-back: when wb_valid, registers[wb_addr] <= wb_data at rising edge. If cnt[wb_addr] > 0, counter decrements; if 0, counter stays 0 and wb_err sets (sticky until reset).
- Issue: issue_ready = !(cnt[issue_dest] == max) || (wb_valid && wb_addr == issue_dest). When issue_valid && issue_ready, counter increments at the edge. issue_ready is combinational; producer must hold request while low.
- Simultaneous issue and write-back to the same register: counter unchanged (net 0); data still written.
- Counter never wraps: saturation is prevented by issue_ready; no decrement below 0.
- flush: at edge all counters become 0; a same-cycle issue is dropped (flush wins); same-cycle write-back data is still written, with no wb_err.
- Reset asserted mid-operation discards in-flight reservations and data; first cycle after deassert behaves as post-reset.
- busy_any is combinational from counter state.

Optional Feature:
Macro REGFILE_BYPASS_EN. When defined, a read port whose rd_addr equals wb_addr with wb_valid high returns wb_data in the same cycle (r0 excluded). Its rd_ready is 1 if that register's counter is 1. Without the macro, reads return stored contents only; the written value and cleared rd_ready appear the cycle after the write-back edge.

Test Plan:
1. Reset mid-run with r5=0x1234 and cnt[5]=1 -> rd_data port0 (addr 5)=0, rd_ready=2'b11, busy_any=0, wb_err=0 immediately, before the next edge.
2. Issue r3 three times (CNT_W=2) -> cnt=3. Fourth issue sees issue_ready=0 and cnt stays 3. Then wb r3=0xAA with issue r3 in the same cycle -> issue_ready=1, cnt stays 3, r3 reads 0xAA next cycle.
3. Issue r7, then wb r7=0xDEAD -> rd_ready for addr 7 is 0 until the edge, then 1 with data 0xDEAD. With REGFILE_BYPASS_EN: rd_data=0xDEAD and rd_ready=1 during the wb cycle.
4. wb r9=0x55 with cnt[9]=0 -> r9 reads 0x55 next cycle, wb_err=1 and stays 1 through later traffic until reset.
5. Issue r0 and wb r0=0xFFFF -> issue_ready=1, r0 reads 0, rd_ready 1, wb_err 0.
6. cnt[4]=2, cnt[6]=1. Assert flush with issue r4 and wb r6=0x77 in the same cycle -> all counters 0, busy_any=0, r6 reads 0x77, wb_err=0.
